// File: rtl/mem_store_pkg.sv
// Shared types for the core-to-memory store write buffer.
package mem_store_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 32;
  localparam int NBYTES    = 4;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_BYTE = 2'b01,
    ST_HALF = 2'b10,
    ST_WORD = 2'b11
  } st_op_e;

  // addr is word aligned; the entry is sized for the widest supported address
  typedef struct packed {
    logic [DEF_AW-1:0]   addr;
    logic [31:0]         wdata;
    logic [NBYTES-1:0]   be;
  } store_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Converts a right-aligned sb/sh/sw request into byte enables and lane-replicated data.
module store_lane_align
  import mem_store_pkg::*;
(
  input  logic [1:0]        memwrite,
  input  logic [1:0]        a,
  input  logic [31:0]       writedata,
  output logic              ok,
  output logic              misalign,
  output logic [NBYTES-1:0] be,
  output logic [31:0]       wdata
);

  st_op_e op;
  logic   req;
  logic   aligned;

  assign op = st_op_e'(memwrite);
  assign req = (op != ST_NONE);

  always_comb begin
    be      = '0;
    aligned = 1'b1;
    unique case (op)
      ST_BYTE: be = 4'b0001 << a;
      ST_HALF: begin
        aligned = ~a[0];
        be      = a[1] ? 4'b1100 : 4'b0011;
      end
      ST_WORD: begin
        aligned = (a == 2'b00);
        be      = 4'b1111;
      end
      default: ;
    endcase
  end

  assign ok       = req & aligned;
  assign misalign = req & ~aligned;

  // Replicate the source byte/half across lanes so be alone selects the target
  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    assign wdata[8*i +: 8] = (op == ST_BYTE) ? writedata[7:0] :
                             (op == ST_HALF) ? writedata[8*(i%2) +: 8] :
                                               writedata[8*i +: 8];
  end

endmodule

// File: rtl/store_write_buffer.sv
// Store FIFO between the core's store port and data memory, with full and load-hazard stalls.
module store_write_buffer
  import mem_store_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
)(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 memwrite,
  input  logic [AW-1:0]              dataadr,
  input  logic [31:0]                writedata,
  input  logic                       memread,
  output logic                       stall,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [AW-1:0]              mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_be,
  output logic                       misalign,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  store_entry_t      ent [DEPTH];
  logic [DEPTH-1:0]  ent_vld, vld_nxt;
  logic [DEPTH-1:0]  match;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     cnt_nxt;
  logic              full_q;

  logic              st_ok, st_bad;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  store_entry_t      new_ent, head;
  logic              enq, deq, hazard;

  store_lane_align u_align (
    .memwrite  (memwrite),
    .a         (dataadr[1:0]),
    .writedata (writedata),
    .ok        (st_ok),
    .misalign  (st_bad),
    .be        (al_be),
    .wdata     (al_wdata)
  );

  always_comb begin
    new_ent       = '0;
    new_ent.addr  = DEF_AW'({dataadr[AW-1:2], 2'b00});
    new_ent.wdata = al_wdata;
    new_ent.be    = al_be;
  end

  assign enq = st_ok & ~full_q;
  assign deq = mem_valid & mem_ready;

  assign head      = ent[rd_ptr];
  assign mem_valid = (count != '0);
  assign mem_addr  = mem_valid ? head.addr[AW-1:0] : '0;
  assign mem_wdata = mem_valid ? head.wdata : '0;
  assign mem_be    = mem_valid ? head.be : '0;

  // Word-granular hazard: any overlap in the same word holds the load
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match[i] = ent_vld[i] & (ent[i].addr[AW-1:2] == dataadr[AW-1:2]);
  end

  // A simultaneous store wins over the (illegal) concurrent load
  assign hazard = memread & (memwrite == ST_NONE) & (|match);
  assign stall  = (st_ok & full_q) | hazard;

  always_comb begin
    vld_nxt = ent_vld;
    if (deq) vld_nxt[rd_ptr] = 1'b0;
    if (enq) vld_nxt[wr_ptr] = 1'b1;
  end

  always_comb begin
    unique case ({enq, deq})
      2'b10:   cnt_nxt = count + CW'(1);
      2'b01:   cnt_nxt = count - CW'(1);
      default: cnt_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      ent_vld  <= '0;
      misalign <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      misalign <= st_bad;
      if (enq) begin
        ent[wr_ptr] <= new_ent;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      ent_vld <= vld_nxt;
      count   <= cnt_nxt;
      full_q  <= (cnt_nxt == CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed vector table, randomized run against a queue model, reset corner.
module tb_store_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  memwrite;
  logic [31:0] dataadr, writedata;
  logic        memread, mem_ready;
  logic        stall, mem_valid, misalign;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [2:0]  count;

  always #5 clk = ~clk;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .memread(memread), .stall(stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .misalign(misalign), .count(count)
  );

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] be; } m_ent_t;
  m_ent_t mq[$];
  bit     m_mis = 1'b0;

  typedef struct {
    logic [1:0] mw; logic [31:0] adr; logic [31:0] wd; logic mr; logic rdy;
    logic stall; logic vld; logic [31:0] addr; logic [31:0] wdata;
    logic [3:0] be; logic mis; logic [2:0] cnt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference conversion straight from the sb/sh/sw rules
  function automatic bit m_conv(input logic [1:0] op, input logic [31:0] adr,
                                input logic [31:0] wd, output m_ent_t e);
    int off;
    off = int'(adr % 4);
    e.addr = adr - 32'(off);
    e.data = 32'h0;
    e.be   = 4'h0;
    case (op)
      2'd1: begin e.be = 4'(1 << off); e.data = {4{wd[7:0]}}; return 1'b1; end
      2'd2: begin e.be = (off >= 2) ? 4'hC : 4'h3; e.data = {2{wd[15:0]}}; return (off % 2) == 0; end
      2'd3: begin e.be = 4'hF; e.data = wd; return off == 0; end
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic [1:0] mw, input logic [31:0] adr, input logic [31:0] wd,
                       input logic mr, input logic rdy);
    memwrite = mw; dataadr = adr; writedata = wd; memread = mr; mem_ready = rdy;
    #2;
  endtask

  // Compare DUT against the model for the current cycle, then advance both across the edge
  task automatic adv();
    m_ent_t e, h;
    bit legal, full, hit, push, pop, mis_n;
    legal = m_conv(memwrite, dataadr, writedata, e);
    full  = (mq.size() == DEPTH);
    hit   = 1'b0;
    foreach (mq[i]) if (mq[i].addr[31:2] == dataadr[31:2]) hit = 1'b1;
    h = '{32'h0, 32'h0, 4'h0};
    if (mq.size() != 0) h = mq[0];
    chk("m_valid", 64'(mem_valid), 64'(mq.size() != 0));
    chk("m_addr",  64'(mem_addr),  64'(h.addr));
    chk("m_wdata", 64'(mem_wdata), 64'(h.data));
    chk("m_be",    64'(mem_be),    64'(h.be));
    chk("m_count", 64'(count),     64'(mq.size()));
    chk("m_misalign", 64'(misalign), 64'(m_mis));
    chk("m_stall", 64'(stall),
        64'((legal && full) || (memread && memwrite == 2'b00 && hit)));
    push  = legal && !full;
    pop   = (mq.size() != 0) && mem_ready;
    mis_n = (memwrite != 2'b00) && !legal;
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(e);
    m_mis = mis_n;
  endtask

  task automatic step(input logic [1:0] mw, input logic [31:0] adr, input logic [31:0] wd,
                      input logic mr, input logic rdy);
    drive(mw, adr, wd, mr, rdy);
    adv();
  endtask

  function automatic vec_t mk(input logic [1:0] mw, input logic [31:0] adr, input logic [31:0] wd,
                              input logic mr, input logic rdy, input logic st, input logic vl,
                              input logic [31:0] ad, input logic [31:0] dt, input logic [3:0] be,
                              input logic ms, input logic [2:0] cn);
    vec_t v;
    v.mw = mw; v.adr = adr; v.wd = wd; v.mr = mr; v.rdy = rdy;
    v.stall = st; v.vld = vl; v.addr = ad; v.wdata = dt; v.be = be; v.mis = ms; v.cnt = cn;
    return v;
  endfunction

  vec_t tv[30];

  initial begin
    tv[0]  = mk(2'd0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 0, 0);
    tv[1]  = mk(2'd3, 32'h84, 32'hFFFF7F02, 0, 1, 0, 0, 32'h00, 32'h0,        4'h0, 0, 0);
    tv[2]  = mk(2'd0, 32'h00, 32'h0,        0, 1, 0, 1, 32'h84, 32'hFFFF7F02, 4'hF, 0, 1);
    tv[3]  = mk(2'd0, 32'h00, 32'h0,        0, 1, 0, 0, 32'h00, 32'h0,        4'h0, 0, 0);
    tv[4]  = mk(2'd1, 32'h85, 32'h000000AB, 0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 0, 0);
    tv[5]  = mk(2'd2, 32'h86, 32'h00001234, 0, 0, 0, 1, 32'h84, 32'hABABABAB, 4'h2, 0, 1);
    tv[6]  = mk(2'd0, 32'h00, 32'h0,        0, 1, 0, 1, 32'h84, 32'hABABABAB, 4'h2, 0, 2);
    tv[7]  = mk(2'd0, 32'h00, 32'h0,        0, 1, 0, 1, 32'h84, 32'h12341234, 4'hC, 0, 1);
    tv[8]  = mk(2'd0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 0, 0);
    tv[9]  = mk(2'd3, 32'h00, 32'h10,       0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 0, 0);
    tv[10] = mk(2'd3, 32'h04, 32'h11,       0, 0, 0, 1, 32'h00, 32'h10,       4'hF, 0, 1);
    tv[11] = mk(2'd3, 32'h08, 32'h12,       0, 0, 0, 1, 32'h00, 32'h10,       4'hF, 0, 2);
    tv[12] = mk(2'd3, 32'h0C, 32'h13,       0, 0, 0, 1, 32'h00, 32'h10,       4'hF, 0, 3);
    tv[13] = mk(2'd3, 32'h10, 32'h14,       0, 0, 1, 1, 32'h00, 32'h10,       4'hF, 0, 4);
    tv[14] = mk(2'd3, 32'h10, 32'h14,       0, 1, 1, 1, 32'h00, 32'h10,       4'hF, 0, 4);
    tv[15] = mk(2'd3, 32'h10, 32'h14,       0, 0, 0, 1, 32'h04, 32'h11,       4'hF, 0, 3);
    tv[16] = mk(2'd0, 32'h00, 32'h0,        0, 1, 0, 1, 32'h04, 32'h11,       4'hF, 0, 4);
    tv[17] = mk(2'd0, 32'h00, 32'h0,        0, 1, 0, 1, 32'h08, 32'h12,       4'hF, 0, 3);
    tv[18] = mk(2'd0, 32'h00, 32'h0,        0, 1, 0, 1, 32'h0C, 32'h13,       4'hF, 0, 2);
    tv[19] = mk(2'd0, 32'h00, 32'h0,        0, 1, 0, 1, 32'h10, 32'h14,       4'hF, 0, 1);
    tv[20] = mk(2'd0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 0, 0);
    tv[21] = mk(2'd3, 32'h84, 32'h55,       0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 0, 0);
    tv[22] = mk(2'd0, 32'h86, 32'h0,        1, 0, 1, 1, 32'h84, 32'h55,       4'hF, 0, 1);
    tv[23] = mk(2'd0, 32'h88, 32'h0,        1, 0, 0, 1, 32'h84, 32'h55,       4'hF, 0, 1);
    tv[24] = mk(2'd0, 32'h86, 32'h0,        1, 1, 1, 1, 32'h84, 32'h55,       4'hF, 0, 1);
    tv[25] = mk(2'd0, 32'h86, 32'h0,        1, 0, 0, 0, 32'h00, 32'h0,        4'h0, 0, 0);
    tv[26] = mk(2'd2, 32'h83, 32'h1234,     0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 0, 0);
    tv[27] = mk(2'd3, 32'h86, 32'h5678,     0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 1, 0);
    tv[28] = mk(2'd0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 1, 0);
    tv[29] = mk(2'd0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h00, 32'h0,        4'h0, 0, 0);

    reset = 1'b1;
    memwrite = 2'd0; dataadr = '0; writedata = '0; memread = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 30; i++) begin
      drive(tv[i].mw, tv[i].adr, tv[i].wd, tv[i].mr, tv[i].rdy);
      chk($sformatf("v%0d_stall", i), 64'(stall), 64'(tv[i].stall));
      chk($sformatf("v%0d_valid", i), 64'(mem_valid), 64'(tv[i].vld));
      chk($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(tv[i].addr));
      chk($sformatf("v%0d_wdata", i), 64'(mem_wdata), 64'(tv[i].wdata));
      chk($sformatf("v%0d_be", i), 64'(mem_be), 64'(tv[i].be));
      chk($sformatf("v%0d_misalign", i), 64'(misalign), 64'(tv[i].mis));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(tv[i].cnt));
      adv();
    end

    // Randomized traffic over a small address window so hazards and wraps are frequent
    for (int n = 0; n < 600; n++) begin
      logic [1:0] mw;
      logic mr;
      mw = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      mr = ($urandom_range(0, 2) == 0);
      if (mw != 2'd0 && $urandom_range(0, 9) != 0) mr = 1'b0;
      step(mw, 32'h100 + 32'($urandom_range(0, 31)), $urandom, mr,
           1'($urandom_range(0, 2) == 0));
    end

    // Drain, then asynchronous reset with three entries pending
    for (int n = 0; n < DEPTH + 1; n++) step(2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(2'd3, 32'h20, 32'hA0, 1'b0, 1'b0);
    step(2'd3, 32'h24, 32'hA1, 1'b0, 1'b0);
    step(2'd3, 32'h28, 32'hA2, 1'b0, 1'b0);
    drive(2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_valid", 64'(mem_valid), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_be", 64'(mem_be), 64'd0);
    reset = 1'b0;
    mq.delete();
    m_mis = 1'b0;
    @(posedge clk);
    #1;
    step(2'd3, 32'h30, 32'hBEEF, 1'b0, 1'b1);
    drive(2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("post_rst_addr", 64'(mem_addr), 64'h30);
    chk("post_rst_wdata", 64'(mem_wdata), 64'hBEEF);
    adv();
    drive(2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("post_rst_count", 64'(count), 64'd0);
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Sits directly downstream of the single-cycle MIPS core's data-memory store port (memwrite/dataadr/writedata) and upstream of the data memory.
- Converts each sb/sh/sw request into a word-aligned address, byte-lane-aligned data and a 4-bit byte enable.
- Queues converted stores in a small FIFO and drains them to memory over a valid/ready handshake.
- Stalls the core when the FIFO is full, or when a load hits a pending store address.

Parameters:
- DEPTH, 4, number of buffered store entries; power of two, at least 2.
- AW, 32, address width.

Ports:
- clk  in  1  core clock.
- reset  in  1  reset; asynchronous, active-high.
- memwrite  in  2  store request: 00 none, 01 sb, 10 sh, 11 sw.
- dataadr  in  AW  store or load byte address.
- writedata  in  32  store data, right-aligned for sb/sh.
- memread  in  1  core is issuing a load this cycle.
- stall  out  1  core must hold its current instruction.
- mem_valid  out  1  head entry is presented to memory.
- mem_ready  in  1  memory accepts the head entry this cycle.
- mem_addr  out  AW  word-aligned address of head entry (bits 1:0 are 0).
- mem_wdata  out  32  lane-aligned data of head entry.
- mem_be  out  4  byte enables of head entry; bit i selects byte i, little-endian.
- misalign  out  1  one-cycle pulse when a misaligned store was rejected.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset state (asynchronous; entries discarded even mid-drain):
  - read pointer, write pointer and count = 0.
  - All entry valid bits = 0.
  - mem_valid = 0, misalign = 0.
  - mem_addr, mem_wdata and mem_be read as 0 while the FIFO is empty.
- Lane conversion, with a = dataadr[1:0]:
  - sb: be = 4'b0001 << a; data = {4{writedata[7:0]}}.
  - sh: legal only if a[0] = 0; be = a[1] ? 4'b1100 : 4'b0011; data = {2{writedata[15:0]}}.
  - sw: legal only if a = 00; be = 4'b1111; data = writedata.
  - mem_addr = {dataadr[AW-1:2], 2'b00}.
- Misaligned store (sh with a[0] = 1, or sw with a != 00):
  - Not enqueued and does not stall.
  - misalign = 1 on the cycle after the request, for exactly one cycle.
- Enqueue:
  - Occurs at the rising edge when memwrite != 00, the store is aligned, and count < DEPTH (registered full flag is clear).
  - Write pointer advances modulo DEPTH.
- Dequeue:
  - Occurs at the rising edge when mem_valid && mem_ready.
  - Read pointer advances modulo DEPTH.
- mem_valid = (count != 0).
  - Head fields are driven combinationally from the entry storage.
  - Head fields are stable while mem_valid && !mem_ready.
- Latency: a store accepted at edge N is presented to memory from edge N onward, i.e. visible in cycle N+1 at the earliest. There is no bypass to memory in the same cycle.
- Simultaneous enqueue and dequeue when not full: count unchanged and both pointers advance.
- Full (count == DEPTH) with a store request: stall = 1 and no enqueue, even if a dequeue occurs in the same cycle. The store enqueues on the following cycle.
- Empty with mem_ready = 1: no dequeue and no pointer change.
- Load hazard:
  - stall = 1 when memread = 1 and dataadr[AW-1:2] matches mem_addr[AW-1:2] of any valid entry.
  - Held until every matching entry has drained.
  - No forwarding.
- stall is combinational: (memwrite != 00 && aligned && full) || load_hazard.
- memwrite != 00 together with memread = 1 is illegal core behaviour; the store takes priority and the hazard check is ignored.
- Pointer wrap-around must preserve FIFO order across DEPTH boundaries.

Decomposition:
- Package mem_store_pkg:
  - Enum for the memwrite encoding (ST_NONE, ST_BYTE, ST_HALF, ST_WORD).
  - Struct store_entry_t holding addr, wdata and be.
  - Default DEPTH constant.
- Sub-module store_lane_align: combinational lane conversion plus the misalign flag, instantiated once.
- FIFO, hazard compare and stall logic stay in store_write_buffer.

Test Plan:
1. sw: memwrite = 11, dataadr = 84, writedata = FFFF7F02, mem_ready = 1 -> next cycle mem_valid = 1, mem_addr = 84, mem_be = F, mem_wdata = FFFF7F02; count returns to 0 after one cycle.
2. sb: memwrite = 01, dataadr = 85, writedata = 000000AB -> mem_addr = 84, mem_be = 0010, mem_wdata = ABABABAB. sh at 86 with data 00001234 -> mem_be = 1100, mem_wdata = 12341234.
3. Fill then overflow: mem_ready = 0, four sw to 0, 4, 8, C -> count = 4; fifth sw -> stall = 1. Pulse mem_ready for one cycle -> address 0 drains, fifth store enqueues next cycle, order 4, 8, C, fifth preserved.
4. Load hazard: entry at 84 pending with mem_ready = 0, then memread = 1, dataadr = 86 -> stall = 1 until mem_ready drains it. A load to 88 causes no stall.
5. Misalign: sh at 83 and sw at 86 -> misalign pulses one cycle each, count stays 0, stall = 0.
6. Reset mid-operation: three entries pending, assert reset between edges -> count = 0 and mem_valid = 0 immediately, before the next clk edge. After release, a new sw drains normally.
